// File: rtl/cfg_scan_loader.sv
// Byte-stream to four-chain scan loader: each byte feeds two shift cycles, and a byte can be accepted on the high-nibble cycle.
// Build option CFG_LOADER_CRC_EN adds a trailing CRC-8 byte that is checked against the data bytes and reported on err_o.
module cfg_scan_loader #(
  parameter int unsigned SHIFT_LEN = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       pclk_i,
  input  logic       prst_i,
  input  logic       start_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       se_o,
  output logic       lb_sin_o,
  output logic       cb1_sin_o,
  output logic       cb2_sin_o,
  output logic       sb_sin_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       urst_req_o
);

`ifdef CFG_LOADER_CRC_EN
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT_LO, SHIFT_HI, CRC_CHK, FINISH} state_t;
  localparam state_t END_ST = CRC_CHK;
`else
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT_LO, SHIFT_HI, FINISH} state_t;
  localparam state_t END_ST = FINISH;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       byte_q, byte_d;
  logic             se_q, se_d;
  logic [3:0]       sin_q, sin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             urst_q, urst_d;
  logic             rdy;

`ifdef CFG_LOADER_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       err_q, err_d;

  // CRC-8, poly 0x07, MSB-first, one whole byte per call.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    rdy     = 1'b0;
`ifdef CFG_LOADER_CRC_EN
    crc_d   = crc_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WAIT_BYTE;
          cnt_d   = '0;
`ifdef CFG_LOADER_CRC_EN
          crc_d   = 8'h00;
          err_d   = 1'b0;
`endif
        end
      end
      WAIT_BYTE: begin
        rdy = 1'b1;
        if (in_valid_i) begin
          byte_d  = in_data_i;
          state_d = SHIFT_LO;
`ifdef CFG_LOADER_CRC_EN
          crc_d   = crc8(crc_q, in_data_i);
`endif
        end
      end
      SHIFT_LO: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == LAST_CNT) ? END_ST : SHIFT_HI;
      end
      SHIFT_HI: begin
        cnt_d = cnt_inc;
        if (cnt_inc == LAST_CNT) begin
          state_d = END_ST;
        end else begin
          // Skid accept keeps a continuous stream at one byte per two cycles.
          rdy = 1'b1;
          if (in_valid_i) begin
            byte_d  = in_data_i;
            state_d = SHIFT_LO;
`ifdef CFG_LOADER_CRC_EN
            crc_d   = crc8(crc_q, in_data_i);
`endif
          end else begin
            state_d = WAIT_BYTE;
          end
        end
      end
`ifdef CFG_LOADER_CRC_EN
      CRC_CHK: begin
        rdy = 1'b1;
        if (in_valid_i) begin
          if (in_data_i != crc_q) err_d = 1'b1;
          state_d = FINISH;
        end
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change only on clock edges.
    se_d   = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    sin_d  = 4'h0;
    if (state_d == SHIFT_LO) sin_d = byte_d[3:0];
    if (state_d == SHIFT_HI) sin_d = byte_d[7:4];
    busy_d = (state_d != IDLE) && (state_d != FINISH);
    done_d = (state_d == FINISH);
    urst_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      se_q    <= 1'b0;
      sin_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      urst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      se_q    <= se_d;
      sin_q   <= sin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      urst_q  <= urst_d;
    end
  end

`ifdef CFG_LOADER_CRC_EN
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      crc_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign in_ready_o = rdy;
  assign se_o       = se_q;
  assign lb_sin_o   = sin_q[0];
  assign cb1_sin_o  = sin_q[1];
  assign cb2_sin_o  = sin_q[2];
  assign sb_sin_o   = sin_q[3];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign urst_req_o = urst_q;

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Directed bench for cfg_scan_loader: SHIFT_LEN=8 and SHIFT_LEN=7 instances, plus SHIFT_LEN=2 with CFG_LOADER_CRC_EN.
module tb_cfg_scan_loader;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic [1:0] sel;

  logic [2:0] start_v, rdy_v, se_v, lb_v, cb1_v, cb2_v, sb_v, busy_v, done_v, err_v, urst_v;
  logic       rdy_m, se_m, busy_m, done_m, err_m, urst_m;
  logic [3:0] nib_m;

  assign start_v[0] = start & (sel == 2'd0);
  assign start_v[1] = start & (sel == 2'd1);
  assign start_v[2] = start & (sel == 2'd2);

  assign rdy_m  = rdy_v[sel];
  assign se_m   = se_v[sel];
  assign busy_m = busy_v[sel];
  assign done_m = done_v[sel];
  assign err_m  = err_v[sel];
  assign urst_m = urst_v[sel];
  assign nib_m  = {sb_v[sel], cb2_v[sel], cb1_v[sel], lb_v[sel]};

  cfg_scan_loader #(.SHIFT_LEN(8), .CNT_W(16)) u8 (
    .pclk_i(clk), .prst_i(rst_n), .start_i(start_v[0]), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(rdy_v[0]), .se_o(se_v[0]), .lb_sin_o(lb_v[0]),
    .cb1_sin_o(cb1_v[0]), .cb2_sin_o(cb2_v[0]), .sb_sin_o(sb_v[0]), .busy_o(busy_v[0]),
    .done_o(done_v[0]), .err_o(err_v[0]), .urst_req_o(urst_v[0]));

  cfg_scan_loader #(.SHIFT_LEN(7), .CNT_W(16)) u7 (
    .pclk_i(clk), .prst_i(rst_n), .start_i(start_v[1]), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(rdy_v[1]), .se_o(se_v[1]), .lb_sin_o(lb_v[1]),
    .cb1_sin_o(cb1_v[1]), .cb2_sin_o(cb2_v[1]), .sb_sin_o(sb_v[1]), .busy_o(busy_v[1]),
    .done_o(done_v[1]), .err_o(err_v[1]), .urst_req_o(urst_v[1]));

`ifdef CFG_LOADER_CRC_EN
  cfg_scan_loader #(.SHIFT_LEN(2), .CNT_W(16)) u2 (
    .pclk_i(clk), .prst_i(rst_n), .start_i(start_v[2]), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(rdy_v[2]), .se_o(se_v[2]), .lb_sin_o(lb_v[2]),
    .cb1_sin_o(cb1_v[2]), .cb2_sin_o(cb2_v[2]), .sb_sin_o(sb_v[2]), .busy_o(busy_v[2]),
    .done_o(done_v[2]), .err_o(err_v[2]), .urst_req_o(urst_v[2]));
`else
  assign rdy_v[2]  = 1'b0;
  assign se_v[2]   = 1'b0;
  assign lb_v[2]   = 1'b0;
  assign cb1_v[2]  = 1'b0;
  assign cb2_v[2]  = 1'b0;
  assign sb_v[2]   = 1'b0;
  assign busy_v[2] = 1'b0;
  assign done_v[2] = 1'b0;
  assign err_v[2]  = 1'b0;
  assign urst_v[2] = 1'b0;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [7:0] bytes_in [8];
  logic [3:0] nib_q [$];
  int         se_cyc_q [$];
  int         done_cyc, acc_cnt, acc0_cyc, urst_done, urst_after, busy_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int se_at(input int i);
    return (i >= 0 && i < se_cyc_q.size()) ? se_cyc_q[i] : -1;
  endfunction

  task automatic chk_nibs(input string tag, input int n);
    chk({tag, "_cnt"}, nib_q.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_%0d", tag, i), (i < nib_q.size()) ? 32'(nib_q[i]) : 32'hFF, i + 1);
  endtask

  // Cycle 0 pulses start; inputs are driven and outputs sampled on falling edges.
  task automatic run_load(input int nb, input int stall_at, input int stall_len, input int extra_start);
    int stall_left = 0;
    bit stall_started = 1'b0;
    nib_q.delete();
    se_cyc_q.delete();
    done_cyc   = -1;
    acc_cnt    = 0;
    acc0_cyc   = -1;
    urst_done  = -1;
    urst_after = -1;
    busy_done  = -1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == extra_start);
      if (!stall_started && stall_len > 0 && acc_cnt == stall_at) begin
        stall_started = 1'b1;
        stall_left    = stall_len;
      end
      if (stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else begin
        in_valid = 1'b1;
      end
      in_data = (acc_cnt < nb) ? bytes_in[acc_cnt] : 8'hEE;
      if (se_m) begin
        nib_q.push_back(nib_m);
        se_cyc_q.push_back(cyc);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        urst_after = int'(urst_m);
        break;
      end
      if (done_m && done_cyc < 0) begin
        done_cyc  = cyc;
        urst_done = int'(urst_m);
        busy_done = int'(busy_m);
      end
      if (in_valid && rdy_m) begin
        if (acc_cnt == 0) acc0_cyc = cyc;
        acc_cnt++;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("load_finished", (done_cyc >= 0 && urst_after >= 0), 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    sel      = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_se",   se_v,   3'b000);
    chk("rst_busy", busy_v, 3'b000);
    chk("rst_done", done_v, 3'b000);
    chk("rst_urst", urst_v, 3'b000);
    chk("rst_rdy",  rdy_v,  3'b000);
    chk("rst_err",  err_v,  3'b000);
    chk("rst_sin",  {lb_v, cb1_v, cb2_v, sb_v}, 12'h000);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Continuous stream, SHIFT_LEN=8
    sel = 2'd0;
    bytes_in = '{8'h21, 8'h43, 8'h65, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(4, -1, 0, -1);
    chk_nibs("t1_nib", 8);
    chk("t1_acc0",      acc0_cyc, 1);
    chk("t1_se_first",  se_at(0), 2);
    chk("t1_se_last",   se_at(7), 9);
    chk("t1_done_cyc",  done_cyc, 10);
    chk("t1_busy_done", busy_done, 0);
    chk("t1_urst_done", urst_done, 1);
    chk("t1_urst_next", urst_after, 0);
    chk("t1_acc_cnt",   acc_cnt, 4);
    chk("t1_err",       err_m, 1'b0);

    // Odd length: high nibble of the last byte is dropped, no fifth byte taken
    sel = 2'd1;
    bytes_in = '{8'h21, 8'h43, 8'h65, 8'hF7, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(4, -1, 0, -1);
    chk_nibs("t2_nib", 7);
    chk("t2_se_last",  se_at(6), 8);
    chk("t2_done_cyc", done_cyc, 9);
    chk("t2_acc_cnt",  acc_cnt, 4);

    // Five-cycle IN_VALID stall after the second byte
    sel = 2'd0;
    bytes_in = '{8'h21, 8'h43, 8'h65, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(4, 2, 5, -1);
    chk_nibs("t3_nib", 8);
    chk("t3_se_pre",   se_at(3), 5);
    chk("t3_se_post",  se_at(4), 10);
    chk("t3_done_cyc", done_cyc, 14);
    chk("t3_acc_cnt",  acc_cnt, 4);

    // START while busy is ignored
    run_load(4, -1, 0, 5);
    chk_nibs("t4_nib", 8);
    chk("t4_done_cyc", done_cyc, 10);
    chk("t4_acc_cnt",  acc_cnt, 4);

    // Asynchronous reset during the third shift cycle
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h21;
    @(negedge clk);
    start = 1'b0;
    chk("t5_rdy_wait", rdy_m, 1'b1);
    @(negedge clk);
    in_data = 8'h43;
    @(negedge clk);
    @(negedge clk);
    chk("t5_se_before", se_m, 1'b1);
    chk("t5_nib_before", nib_m, 4'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_se_async",   se_m,   1'b0);
    chk("t5_busy_async", busy_m, 1'b0);
    chk("t5_urst_async", urst_m, 1'b0);
    chk("t5_done_async", done_m, 1'b0);
    chk("t5_nib_async",  nib_m,  4'h0);
    chk("t5_rdy_async",  rdy_m,  1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    run_load(4, -1, 0, -1);
    chk_nibs("t5_nib", 8);
    chk("t5_done_cyc", done_cyc, 10);

`ifdef CFG_LOADER_CRC_EN
    // CRC-8 of 0x01 is 0x07
    sel = 2'd2;
    bytes_in = '{8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(2, -1, 0, -1);
    chk("c1_acc_cnt",  acc_cnt, 2);
    chk("c1_done_cyc", done_cyc, 5);
    chk("c1_err",      err_m, 1'b0);
    bytes_in = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(2, -1, 0, -1);
    chk("c2_done_cyc", done_cyc, 5);
    chk("c2_err",      err_m, 1'b1);
    repeat (3) @(negedge clk);
    chk("c2_err_sticky", err_m, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("c2_err_clear", err_m, 1'b0);
    chk("c2_busy",      busy_m, 1'b1);
`else
    chk("nocrc_err", err_v, 3'b000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
